vfd_scan_ctrl: RTL and testbench
================================

// Module: vfd_scan_ctrl
// PURPOSE
//  Multiplexing scan controller for the VFD driven by the shiftout serializer.
//  Holds one segment word per grid, walks the grids round-robin and, for each grid,
//  sends a blanking frame and then a {grid one-hot, segments} frame to shiftout.
//  It then dwells for a fixed time. Sits between user logic (segment writes) and shiftout.
//  Output frames are active-high; any polarity inversion belongs at top level.
// PARAMETERS
//  DISPLAY_BITS  25     frame width passed to shiftout; must equal NUM_GRIDS+SEG_BITS
//  NUM_GRIDS     9      number of grids scanned (>=2)
//  SEG_BITS      16     segment bits per grid
//  DWELL_CYCLES  12000  ICE_CLK cycles each grid stays lit after its frame is accepted (>=1)
//  ACK_TIMEOUT   64     cycles to wait for shift_busy to rise before re-issuing a frame
// PORTS
//  ICE_CLK      in   1                  system clock
//  RST          in   1                  asynchronous reset, active-high
//  enable       in   1                  1 = scan; 0 = blank the display and stop
//  wr_en        in   1                  segment-memory write strobe
//  wr_addr      in   $clog2(NUM_GRIDS)  grid index to write; values >= NUM_GRIDS are ignored
//  wr_data      in   SEG_BITS           segment pattern for that grid
//  shift_busy   in   1                  busy flag from shiftout
//  shift_data   out  DISPLAY_BITS       frame to shiftout: {grid_onehot[NUM_GRIDS-1:0], seg[SEG_BITS-1:0]}
//  shift_valid  out  1                  one-cycle strobe; shiftout accepts shift_data on this cycle
//  grid_idx     out  $clog2(NUM_GRIDS)  grid currently being scanned
//  frame_done   out  1                  one-cycle pulse when grid_idx wraps NUM_GRIDS-1 -> 0
// BEHAVIOUR
//  Reset (async, while RST=1):
//   - Outputs: shift_data=0, shift_valid=0, grid_idx=0, frame_done=0.
//   - Internal state: segment memory all 0, state=IDLE.
//  FSM states: IDLE, BLANK, BLANK_ACK, BLANK_WAIT, SEG, SEG_ACK, SEG_WAIT, DWELL.
//  IDLE:
//   - enable=1 -> BLANK.
//   - Otherwise stay in IDLE; shift_data holds its last value.
//  BLANK / SEG (issue states):
//   - On a cycle with shift_busy=0: drive shift_valid=1 for exactly 1 cycle.
//     BLANK drives shift_data=0; SEG drives {onehot(grid_idx), mem[grid_idx]}.
//     Then go to BLANK_ACK / SEG_ACK.
//   - While shift_busy=1: hold and do not assert shift_valid.
//  *_ACK:
//   - Wait for shift_busy=1, then go to *_WAIT.
//   - After ACK_TIMEOUT cycles without busy rising, return to the issue state and re-send the frame.
//  *_WAIT:
//   - Wait for shift_busy=0 (transfer latched).
//   - BLANK_WAIT -> SEG. SEG_WAIT -> DWELL with the dwell counter loaded to DWELL_CYCLES-1.
//  DWELL:
//   - Count down to 0.
//   - At 0: advance grid_idx (wraps NUM_GRIDS-1 -> 0) and go to BLANK, or to IDLE if enable=0.
//   - frame_done pulses on the same cycle as the wrap.
//  enable deasserted mid-scan:
//   - A frame already issued completes its ACK/WAIT.
//   - The controller then issues one blanking frame and goes to IDLE.
//   - grid_idx is retained; scanning resumes from it on re-enable.
//  shift_data is stable from the shift_valid cycle until the following *_WAIT exit.
//  Segment memory:
//   - Written on any cycle with wr_en=1 and wr_addr < NUM_GRIDS, in any state.
//   - The SEG frame samples mem[grid_idx] on its issue cycle.
//   - A same-cycle write to that address is not seen; it appears on the next scan of that grid.
//  Reset mid-transfer: the controller returns to IDLE immediately. shiftout has no reset;
//   the next BLANK issue waits for shift_busy=0, so no partial frame is corrupted.
//  Throughput: one grid per (2 transfers + DWELL_CYCLES) cycles; no combinational path from
//   shift_busy to shift_valid other than the issue-state qualification.
// TESTING
//  1 Reset then enable=1, shiftout model (busy 1 cycle after valid, 30 cycles long).
//    -> first valid carries 0; second carries {9'b000000001, mem[0]=16'h0000}.
//  2 Write mem[3]=16'hA5C3 before enable.
//    -> grid 3 frame = {9'b000001000, 16'hA5C3} = 25'h008A5C3.
//  3 Full scan with DWELL_CYCLES=10.
//    -> grid_idx sequence 0..8,0; exactly one frame_done, on the 8->0 wrap; 18 valids per scan.
//  4 shift_busy held high by model for 100 cycles.
//    -> no shift_valid during that time; issue occurs on the first cycle busy=0.
//  5 Model never raises busy.
//    -> frame re-issued every ACK_TIMEOUT+1 cycles with identical shift_data.
//  6 enable=0 during SEG_WAIT of grid 5.
//    -> one zero frame sent, then IDLE; re-enable resumes at grid 6.
//  7 RST pulsed during SEG_ACK.
//    -> all outputs 0 immediately and mem cleared; clean restart from grid 0.

Source files
------------

// File: rtl/vfd_scan_ctrl_if.sv
// VFD scan controller bus: segment writes, shiftout handshake and scan status.
interface vfd_scan_ctrl_if #(
    parameter int NUM_GRIDS    = 9,
    parameter int SEG_BITS     = 16,
    parameter int DISPLAY_BITS = 25
);
    localparam int AW = $clog2(NUM_GRIDS);

    logic                    enable;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [SEG_BITS-1:0]     wr_data;
    logic                    shift_busy;
    logic [DISPLAY_BITS-1:0] shift_data;
    logic                    shift_valid;
    logic [AW-1:0]           grid_idx;
    logic                    frame_done;

    modport master (
        input  enable, wr_en, wr_addr, wr_data, shift_busy,
        output shift_data, shift_valid, grid_idx, frame_done
    );

    modport slave (
        output enable, wr_en, wr_addr, wr_data, shift_busy,
        input  shift_data, shift_valid, grid_idx, frame_done
    );
endinterface

// File: rtl/vfd_scan_ctrl.sv
// VFD multiplex scan controller: per-grid blank frame, segment frame, then dwell.
module vfd_scan_ctrl #(
    parameter int DISPLAY_BITS = 25,
    parameter int NUM_GRIDS    = 9,
    parameter int SEG_BITS     = 16,
    parameter int DWELL_CYCLES = 12000,
    parameter int ACK_TIMEOUT  = 64
) (
    input logic             ICE_CLK,
    input logic             RST,
    vfd_scan_ctrl_if.master bus
);
    localparam int AW = $clog2(NUM_GRIDS);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [AW-1:0] LAST_GRID = AW'(NUM_GRIDS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [DW-1:0] DWELL_LD  = DW'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, BLANK, BLANK_ACK, BLANK_WAIT,
        SEG, SEG_ACK, SEG_WAIT, DWELL
    } state_t;

    state_t                  state, state_nx;
    logic [SEG_BITS-1:0]     mem [NUM_GRIDS];
    logic [AW-1:0]           grid_q, grid_nx;
    logic [TW-1:0]           tmo_q, tmo_nx;
    logic [DW-1:0]           dwell_q, dwell_nx;
    logic [DISPLAY_BITS-1:0] data_q, frame;
    logic [NUM_GRIDS-1:0]    onehot;
    logic                    issue, valid, advance, done_q, done_nx;

    assign onehot = {{(NUM_GRIDS-1){1'b0}}, 1'b1} << grid_q;
    assign frame  = (state == SEG) ? {onehot, mem[grid_q]} : '0;
    assign issue  = (state == BLANK) || (state == SEG);
    assign valid  = issue && !bus.shift_busy;

    // Frame is live on the issue cycle, then held until the transfer is latched
    assign bus.shift_valid = valid;
    assign bus.shift_data  = issue ? frame : data_q;
    assign bus.grid_idx    = grid_q;
    assign bus.frame_done  = done_q;

    always_comb begin
        state_nx = state;
        grid_nx  = grid_q;
        tmo_nx   = tmo_q;
        dwell_nx = dwell_q;
        done_nx  = 1'b0;
        advance  = 1'b0;
        unique case (state)
            IDLE: if (bus.enable) state_nx = BLANK;
            BLANK, SEG: begin
                if (!bus.shift_busy) begin
                    tmo_nx   = '0;
                    state_nx = (state == BLANK) ? BLANK_ACK : SEG_ACK;
                end
            end
            BLANK_ACK, SEG_ACK: begin
                if (bus.shift_busy)
                    state_nx = (state == BLANK_ACK) ? BLANK_WAIT : SEG_WAIT;
                else if (tmo_q == TMO_LAST)
                    state_nx = (state == BLANK_ACK) ? BLANK : SEG;
                else
                    tmo_nx = tmo_q + 1'b1;
            end
            BLANK_WAIT: begin
                if (!bus.shift_busy) state_nx = bus.enable ? SEG : IDLE;
            end
            SEG_WAIT: begin
                if (!bus.shift_busy) begin
                    if (bus.enable) begin
                        state_nx = DWELL;
                        dwell_nx = DWELL_LD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (dwell_q == '0 || !bus.enable) advance = 1'b1;
                else dwell_nx = dwell_q - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // A disable while lit still goes through BLANK, whose exit lands in IDLE
        if (advance) begin
            state_nx = BLANK;
            done_nx  = (grid_q == LAST_GRID);
            grid_nx  = (grid_q == LAST_GRID) ? '0 : grid_q + 1'b1;
        end
    end

    always_ff @(posedge ICE_CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            grid_q  <= '0;
            tmo_q   <= '0;
            dwell_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            grid_q  <= grid_nx;
            tmo_q   <= tmo_nx;
            dwell_q <= dwell_nx;
            done_q  <= done_nx;
            if (valid) data_q <= frame;
        end
    end

    always_ff @(posedge ICE_CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_GRIDS; i++) mem[i] <= '0;
        end else if (bus.wr_en && bus.wr_addr <= LAST_GRID) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_vfd_scan_ctrl.sv
// Directed bench for vfd_scan_ctrl with a small shiftout responder.
module tb_vfd_scan_ctrl;
    logic ice_clk = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;

    vfd_scan_ctrl_if #(.NUM_GRIDS(9), .SEG_BITS(16), .DISPLAY_BITS(25)) bus ();

    vfd_scan_ctrl #(
        .DISPLAY_BITS(25), .NUM_GRIDS(9), .SEG_BITS(16),
        .DWELL_CYCLES(10), .ACK_TIMEOUT(64)
    ) dut (
        .ICE_CLK(ice_clk),
        .RST    (rst),
        .bus    (bus)
    );

    always #5 ice_clk = ~ice_clk;
    always @(posedge ice_clk) cyc <= cyc + 1;

    // shiftout responder: busy one cycle after valid, for 30 cycles
    logic mdl_busy   = 1'b0;
    int   mdl_cnt    = 0;
    logic mdl_mute   = 1'b0;
    logic force_busy = 1'b0;
    assign bus.shift_busy = mdl_busy | force_busy;

    always @(posedge ice_clk) begin
        if (mdl_cnt > 0) begin
            mdl_cnt  <= mdl_cnt - 1;
            mdl_busy <= (mdl_cnt > 1);
        end else if (bus.shift_valid && !mdl_mute) begin
            mdl_cnt  <= 30;
            mdl_busy <= 1'b1;
        end
    end

    logic [24:0] vq [$];
    int          vt [$];
    int          gq [$];
    int          fd_cnt  = 0;
    int          fd_cyc  = 0;
    int          fd_grid = 0;

    always @(negedge ice_clk) begin
        if (bus.shift_valid) begin
            vq.push_back(bus.shift_data);
            vt.push_back(cyc);
            gq.push_back(int'(bus.grid_idx));
        end
        if (bus.frame_done) begin
            fd_cnt++;
            fd_cyc  = cyc;
            fd_grid = int'(bus.grid_idx);
        end
    end

    logic [15:0] m [9];

    function automatic logic [31:0] segf(input int k, input logic [15:0] d);
        return (32'd1 << (16 + k)) | {16'd0, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ice_clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_nv(input int n, input int lim, input string tag);
        int i = 0;
        while (vq.size() < n && i < lim) begin
            @(negedge ice_clk);
            i++;
        end
        chk(tag, 32'(vq.size() >= n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n0, rel, seen;
        bus.enable  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < 9; i++) m[i] = 16'h0;
        m[3] = 16'hA5C3; m[5] = 16'h1234; m[6] = 16'h0606;
        m[7] = 16'h7007; m[8] = 16'hFFFF;

        repeat (3) @(negedge ice_clk);
        chk("rst_data",  32'(bus.shift_data),  32'd0);
        chk("rst_valid", 32'(bus.shift_valid), 32'd0);
        chk("rst_grid",  32'(bus.grid_idx),    32'd0);
        chk("rst_fd",    32'(bus.frame_done),  32'd0);
        tick();
        rst = 1'b0;

        for (int i = 1; i < 9; i++) if (m[i] != 0) wr(i, m[i]);
        wr(9, 16'hDEAD);

        // full scan
        tick();
        bus.enable = 1'b1;
        wait_nv(19, 2000, "scan_wait");
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("blank%0d", k), 32'(vq[2*k]), 32'd0);
            chk($sformatf("seg%0d", k), 32'(vq[2*k+1]), segf(k, m[k]));
            chk($sformatf("grid%0d", k), 32'(gq[2*k+1]), 32'(k));
        end
        chk("wrap_blank", 32'(vq[18]), 32'd0);
        chk("wrap_grid",  32'(gq[18]), 32'd0);
        chk("fd_count",   32'(fd_cnt), 32'd1);
        chk("fd_cycle",   32'(fd_cyc), 32'(vt[18]));
        chk("fd_grid",    32'(fd_grid), 32'd0);
        chk("blank2seg",  32'(vt[1] - vt[0]), 32'd32);
        chk("seg2blank",  32'(vt[2] - vt[1]), 32'd42);

        // write while scanning; seen on grid 0 of scan 2
        m[0] = 16'hC0DE;
        wr(0, m[0]);
        wait_nv(20, 200, "scan2_wait");
        chk("seg0_scan2", 32'(vq[19]), segf(0, m[0]));

        // busy held high across the BLANK issue of grid 1
        repeat (35) @(negedge ice_clk);
        tick();
        force_busy = 1'b1;
        n0 = vq.size();
        repeat (100) tick();
        chk("busy_hold", 32'(vq.size()), 32'(n0));
        force_busy = 1'b0;
        rel = cyc;
        wait_nv(n0 + 1, 50, "busy_rel_wait");
        chk("busy_rel_cyc",  32'(vt[n0]), 32'(rel));
        chk("busy_rel_data", 32'(vq[n0]), 32'd0);
        chk("busy_rel_grid", 32'(gq[n0]), 32'd1);

        // disable during SEG_WAIT of grid 5
        wait_nv(30, 1000, "g5_wait");
        chk("g5_seg", 32'(vq[29]), segf(5, m[5]));
        repeat (5) @(negedge ice_clk);
        tick();
        bus.enable = 1'b0;
        repeat (150) tick();
        chk("off_count", 32'(vq.size()), 32'd31);
        chk("off_blank", 32'(vq[30]), 32'd0);
        chk("off_grid",  32'(bus.grid_idx), 32'd6);

        // re-enable; write grid 6 on its SEG issue cycle
        bus.enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 200 && seen < 2; i++) begin
            tick();
            if (bus.shift_valid) seen++;
        end
        chk("reen_seen", 32'(seen), 32'd2);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd6;
        bus.wr_data = 16'hBEEF;
        tick();
        bus.wr_en   = 1'b0;
        wait_nv(33, 50, "g6_wait");
        chk("g6_old",  32'(vq[32]), segf(6, 16'h0606));
        chk("g6_blnk", 32'(vq[31]), 32'd0);
        wait_nv(51, 1500, "g6_next_wait");
        chk("g6_new",  32'(vq[50]), segf(6, 16'hBEEF));

        // shiftout never acknowledges the grid 7 segment frame
        wait_nv(52, 200, "g7_blank_wait");
        repeat (3) @(negedge ice_clk);
        tick();
        mdl_mute = 1'b1;
        wait_nv(55, 400, "retry_wait");
        chk("retry_d0", 32'(vq[52]), segf(7, m[7]));
        chk("retry_d1", 32'(vq[53]), segf(7, m[7]));
        chk("retry_d2", 32'(vq[54]), segf(7, m[7]));
        chk("retry_t1", 32'(vt[53] - vt[52]), 32'd65);
        chk("retry_t2", 32'(vt[54] - vt[53]), 32'd65);

        // reset while in SEG_ACK
        repeat (3) @(negedge ice_clk);
        tick();
        rst = 1'b1;
        #2;
        chk("arst_data",  32'(bus.shift_data),  32'd0);
        chk("arst_valid", 32'(bus.shift_valid), 32'd0);
        chk("arst_grid",  32'(bus.grid_idx),    32'd0);
        chk("arst_fd",    32'(bus.frame_done),  32'd0);
        tick();
        tick();
        vq.delete();
        vt.delete();
        gq.delete();
        mdl_mute = 1'b0;
        rst = 1'b0;
        wait_nv(8, 1000, "restart_wait");
        chk("restart_blank", 32'(vq[0]), 32'd0);
        chk("restart_g0",    32'(vq[1]), segf(0, 16'h0));
        chk("restart_g3",    32'(vq[7]), segf(3, 16'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
